// File: rtl/pwm2bin_32bit.sv
// rtl/pwm2bin_32bit.sv - PWM audio capture: four 256-cycle slot high-times packed into a 32-bit word
module pwm2bin_32bit #(
   parameter int SYNC_STAGES = 2
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        aud_en,
   input  logic        pwm_i,
   output logic [31:0] data_o,
   output logic        valid_o,
   input  logic        ready_i,
   output logic        overflow_o,
   output logic        glitch_o
);

   logic [SYNC_STAGES-1:0] pwm_sync;
   logic [SYNC_STAGES-1:0] en_sync;
   logic                   pwm_s;
   logic                   en_s;
   logic [9:0]             rc;
   logic [8:0]             h;
   logic [8:0]             h_cur;
   logic [8:0]             h_dec;
   logic [7:0]             sample;
   logic [7:0]             shadow0;
   logic [7:0]             shadow1;
   logic [7:0]             shadow2;
   logic                   slot_end;
   logic                   word_done;

   // Identical chains keep the PWM edge and its frame reference cycle-aligned.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         pwm_sync <= '0;
         en_sync  <= '0;
      end else begin
         pwm_sync <= {pwm_sync[SYNC_STAGES-2:0], pwm_i};
         en_sync  <= {en_sync[SYNC_STAGES-2:0], aud_en};
      end
   end

   assign pwm_s = pwm_sync[SYNC_STAGES-1];
   assign en_s  = en_sync[SYNC_STAGES-1];

   always_comb begin
      h_cur     = h + {8'd0, pwm_s};
      h_dec     = h_cur - 9'd1;
      sample    = (h_cur == 9'd0) ? 8'd0 : h_dec[7:0];
      slot_end  = en_s && (rc[7:0] == 8'hFF);
      word_done = slot_end && (rc[9:8] == 2'd3);
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         rc         <= '0;
         h          <= '0;
         shadow0    <= '0;
         shadow1    <= '0;
         shadow2    <= '0;
         overflow_o <= 1'b0;
         glitch_o   <= 1'b0;
      end else if (!en_s) begin
         rc         <= '0;
         h          <= '0;
         shadow0    <= '0;
         shadow1    <= '0;
         shadow2    <= '0;
         overflow_o <= 1'b0;
         glitch_o   <= 1'b0;
      end else begin
         rc <= rc + 10'd1;
         h  <= slot_end ? 9'd0 : h_cur;
         if (slot_end) begin
            case (rc[9:8])
               2'd0:    shadow0 <= sample;
               2'd1:    shadow1 <= sample;
               2'd2:    shadow2 <= sample;
               default: ;
            endcase
            if (h_cur == 9'd0)
               glitch_o <= 1'b1;
         end
         if (word_done && valid_o && !ready_i)
            overflow_o <= 1'b1;
      end
   end

   // Output register is independent of en_s so a held word survives aud_en dropping.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         data_o  <= '0;
         valid_o <= 1'b0;
      end else if (word_done && (!valid_o || ready_i)) begin
         data_o  <= {sample, shadow2, shadow1, shadow0};
         valid_o <= 1'b1;
      end else if (valid_o && ready_i) begin
         valid_o <= 1'b0;
      end
   end

endmodule

// File: tb/tb_pwm2bin_32bit.sv
// tb/tb_pwm2bin_32bit.sv - directed bench for pwm2bin_32bit driven by an ideal same-clock PWM source
module tb_pwm2bin_32bit;

   logic        clk;
   logic        rstn;
   logic        aud_en;
   logic        pwm_i;
   logic [31:0] data_o;
   logic        valid_o;
   logic        ready_i;
   logic        overflow_o;
   logic        glitch_o;

   int n_cmp  = 0;
   int n_fail = 0;
   int pos    = 0;
   int hc [4];

   pwm2bin_32bit #(.SYNC_STAGES(2)) dut (
      .clk        (clk),
      .rstn       (rstn),
      .aud_en     (aud_en),
      .pwm_i      (pwm_i),
      .data_o     (data_o),
      .valid_o    (valid_o),
      .ready_i    (ready_i),
      .overflow_o (overflow_o),
      .glitch_o   (glitch_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // pos counts cycles since aud_en rose; slot high count comes from hc[]
   task automatic tick();
      pwm_i = aud_en && ((pos % 256) < hc[(pos / 256) % 4]);
      @(posedge clk);
      #1;
      if (aud_en) pos++;
   endtask

   task automatic run_to(input int target);
      while (pos < target) tick();
   endtask

   task automatic load_word(input logic [31:0] w);
      for (int i = 0; i < 4; i++) hc[i] = int'(w[8*i +: 8]) + 1;
   endtask

   task automatic load_counts(input int c0, input int c1, input int c2, input int c3);
      hc[0] = c0; hc[1] = c1; hc[2] = c2; hc[3] = c3;
   endtask

   initial begin
      rstn    = 1'b0;
      aud_en  = 1'b0;
      pwm_i   = 1'b0;
      ready_i = 1'b0;
      load_counts(0, 0, 0, 0);
      repeat (3) tick();
      check("rst_data", data_o, 32'h0);
      check("rst_valid", {31'd0, valid_o}, 32'd0);
      check("rst_ovf", {31'd0, overflow_o}, 32'd0);
      check("rst_glitch", {31'd0, glitch_o}, 32'd0);
      rstn = 1'b1;
      repeat (2) tick();

      // Loopback and first-word latency
      ready_i = 1'b1;
      load_word(32'hA53C00FF);
      pos = 0;
      aud_en = 1'b1;
      run_to(1024);
      check("early_valid", {31'd0, valid_o}, 32'd0);
      while (!valid_o && pos < 1100) tick();
      check("latency", pos, 32'd1026);
      check("loop_data0", data_o, 32'hA53C00FF);
      check("loop_ovf", {31'd0, overflow_o}, 32'd0);
      check("loop_glitch", {31'd0, glitch_o}, 32'd0);
      tick();
      check("pulse_low", {31'd0, valid_o}, 32'd0);
      while (!valid_o && pos < 2100) tick();
      check("period", pos, 32'd2050);
      check("loop_data1", data_o, 32'hA53C00FF);

      // Extremes
      run_to(3072); load_counts(256, 256, 256, 256);
      run_to(3074); check("loop_data2", data_o, 32'hA53C00FF);
      run_to(4096); load_counts(1, 1, 1, 1);
      run_to(4098); check("all_ones", data_o, 32'hFFFFFFFF);
      check("ones_valid", {31'd0, valid_o}, 32'd1);
      run_to(5120); load_counts(10, 20, 0, 30);
      run_to(5122); check("all_zero", data_o, 32'h00000000);
      check("zero_noglitch", {31'd0, glitch_o}, 32'd0);
      run_to(6144); load_word(32'h11223344);
      run_to(6146); check("glitch_word", data_o, 32'h1D001309);
      check("glitch_set", {31'd0, glitch_o}, 32'd1);

      // Backpressure
      tick();
      ready_i = 1'b0;
      run_to(7168); load_word(32'h55667788);
      run_to(7170); check("bp_data0", data_o, 32'h11223344);
      check("bp_ovf0", {31'd0, overflow_o}, 32'd0);
      run_to(8192); load_word(32'h01020304);
      run_to(8194); check("bp_data1", data_o, 32'h11223344);
      check("bp_valid", {31'd0, valid_o}, 32'd1);
      check("bp_ovf1", {31'd0, overflow_o}, 32'd1);
      ready_i = 1'b1;
      tick();
      ready_i = 1'b0;
      check("bp_accept", {31'd0, valid_o}, 32'd0);

      // aud_en dropped mid-frame, then re-raised
      run_to(8192 + 602);
      aud_en = 1'b0;
      repeat (8) tick();
      check("drop_ovf", {31'd0, overflow_o}, 32'd0);
      check("drop_glitch", {31'd0, glitch_o}, 32'd0);
      check("drop_data", data_o, 32'h11223344);
      load_word(32'h0F1E2D3C);
      pos = 0;
      aud_en = 1'b1;
      run_to(1024);
      check("partial_none", {31'd0, valid_o}, 32'd0);
      load_word(32'hC3B2A190);
      while (!valid_o && pos < 1100) tick();
      check("reraise_lat", pos, 32'd1026);
      check("reraise_data", data_o, 32'h0F1E2D3C);

      // Accept coincident with completion
      run_to(2049);
      ready_i = 1'b1;
      tick();
      ready_i = 1'b0;
      check("simul_data", data_o, 32'hC3B2A190);
      check("simul_valid", {31'd0, valid_o}, 32'd1);
      check("simul_ovf", {31'd0, overflow_o}, 32'd0);

      // Asynchronous reset mid-frame with a word held
      run_to(2048 + 902);
      #2;
      rstn = 1'b0;
      #1;
      check("arst_data", data_o, 32'h0);
      check("arst_valid", {31'd0, valid_o}, 32'd0);
      check("arst_ovf", {31'd0, overflow_o}, 32'd0);
      check("arst_glitch", {31'd0, glitch_o}, 32'd0);
      aud_en = 1'b0;
      repeat (3) tick();
      rstn = 1'b1;
      repeat (2) tick();
      load_word(32'h7E81FF01);
      pos = 0;
      aud_en = 1'b1;
      run_to(1024);
      check("post_rst_early", {31'd0, valid_o}, 32'd0);
      while (!valid_o && pos < 1100) tick();
      check("post_rst_lat", pos, 32'd1026);
      check("post_rst_data", data_o, 32'h7E81FF01);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/pwm2bin_32bit.md
Name: pwm2bin_32bit

Overview:
- Audio PWM capture/demodulator: the receive-side counterpart of the team's 32-bit-word-to-PWM transmitter.
- Measures the high time of each 256-cycle PWM slot and recovers one 8-bit sample per slot.
- Packs four consecutive slots into a 32-bit word; slot 0 goes to bits [7:0], slot 3 to bits [31:24].
- Presents the word on a valid/ready interface. Used for loopback test of the audio path and for capturing external PWM audio.

Parameters:
SYNC_STAGES, 2, number of flops in the pwm_i and aud_en synchronizers (>=2)

Ports:
clk  input  1  system clock; same frequency as the transmitter clock
rstn  input  1  asynchronous active-low reset
aud_en  input  1  capture enable; frame alignment reference, tied to the transmitter's aud_en
pwm_i  input  1  PWM input; high for duty+1 cycles at the start of each 256-cycle slot
data_o  output  32  captured word {s3,s2,s1,s0}
valid_o  output  1  data_o holds an unconsumed word
ready_i  input  1  consumer accepts data_o when valid_o&&ready_i
overflow_o  output  1  sticky: a completed word was dropped
glitch_o  output  1  sticky: a slot contained zero high cycles

Behaviour:
- Reset: rstn is asynchronous, active-low; clock clk. All flops clear.
  - data_o=0, valid_o=0, overflow_o=0, glitch_o=0.
  - Synchronizers, counter, accumulators and shadow word = 0.
- Synchronization:
  - pwm_s = pwm_i through SYNC_STAGES flops.
  - en_s = aud_en through an identical SYNC_STAGES chain, so the PWM and its enable stay cycle-aligned.
- Frame counter rc[9:0]:
  - Held at 0 while en_s=0.
  - Increments by 1 each cycle while en_s=1, wrapping 1023->0.
  - rc[9:8] = slot index k; rc[7:0] = position within slot.
- Slot accumulator h[8:0]:
  - Counts cycles with pwm_s=1 within the current slot, including the rc[7:0]==255 cycle.
  - Range 0..256.
- Slot end (en_s=1 and rc[7:0]==255), using the final h including this cycle:
  - Sample = h-1 for h in 1..256. h=256 gives 255; h=1 gives 0.
  - h=0 gives sample 0 and sets glitch_o.
  - Sample is written to shadow byte k.
  - h restarts at 0 for the next slot, loading pwm_s of the next cycle normally.
- Word completion (slot end with k==3), on the same edge:
  - If valid_o=0, or ready_i=1 in this cycle: data_o <= {byte3_new,shadow2,shadow1,shadow0}; valid_o <= 1.
  - If valid_o=1 and ready_i=0: the new word is discarded, data_o is unchanged, and overflow_o <= 1.
- Handshake:
  - valid_o && ready_i with no word completing: valid_o <= 0 on that edge.
  - data_o is held stable while valid_o=1 and ready_i=0.
- Latency: the first word after aud_en rises sets valid_o 1024+SYNC_STAGES cycles after the first clk edge that samples aud_en=1 (±0 with an ideal transmitter on the same clock).
- aud_en deassertion mid-frame (en_s=0):
  - rc, h and shadow bytes clear; the partial word is discarded.
  - overflow_o and glitch_o clear.
  - data_o/valid_o keep any held word until it is accepted.
- Reset mid-operation: immediate clear of everything; no word is emitted.
- Continuous streaming with ready_i=1: one word every 1024 cycles, no gaps, no overflow.

Test Plan:
- Loopback with the transmitter, data_i=32'hA5_3C_00_FF, aud_en=1, ready_i=1 -> data_o=32'hA53C00FF with valid_o pulsing once per 1024 cycles; first pulse at cycle 1024+SYNC_STAGES; overflow_o=0, glitch_o=0.
- Extremes, pwm_i forced 1 for a whole frame -> word 32'hFFFFFFFF. pwm_i high for exactly 1 cycle per slot -> 32'h00000000, glitch_o=0. pwm_i=0 for slot 2 -> byte2=0x00 and glitch_o=1.
- Backpressure, ready_i=0 for 2 frames (words 32'h11223344 then 32'h55667788) -> data_o stays 32'h11223344, valid_o=1, overflow_o=1. ready_i=1 for 1 cycle -> valid_o=0.
- Simultaneous accept and completion: ready_i=1 exactly on the completion cycle with valid_o=1 -> data_o updates to the new word, valid_o stays 1, overflow_o stays 0.
- aud_en dropped at rc=600 then re-raised -> no word from the partial frame. The next word equals a full frame captured from the re-raise; overflow_o/glitch_o cleared.
- rstn pulsed low at rc=900 with valid_o=1 -> all outputs 0 asynchronously. After release, the first word appears 1024+SYNC_STAGES cycles after aud_en is next sampled high.
